mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port between the instruction-fetch path and the
//  data-access path driven by the request unit (iREN / dREN / dWEN).
//  Registered grant FSM, data priority with an anti-starvation limit,
//  and per-requester wait/ack signalling. Sits between the request unit
//  and the RAM model/controller.
// PARAMETERS
//  DSTREAK_MAX  4  consecutive data grants allowed while iREN is pending; 1..15
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   asynchronous, active-low reset
//  iREN      in   1   instruction read request (level, held until ack)
//  iaddr     in   32  instruction address
//  iwait     out  1   0 = iload valid this cycle (ack), else 1
//  iload     out  32  instruction read data
//  dREN      in   1   data read request (level)
//  dWEN      in   1   data write request (level)
//  daddr     in   32  data address
//  dstore    in   32  data write value
//  dwait     out  1   0 = data access completes this cycle (ack), else 1
//  dload     out  32  data read data
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// BEHAVIOUR
//  - States: IDLE, DGRANT, IGRANT; 4-bit streak counter dcnt.
//  - Reset (nRST=0, async): state=IDLE, dcnt=0; ramREN=ramWEN=0,
//    ramaddr=ramstore=0, iwait=dwait=1, iload=dload=ramload pass-through.
//  - IDLE: ramREN=ramWEN=0. Next state by priority:
//    (dREN|dWEN) & ~(iREN & dcnt>=DSTREAK_MAX) -> DGRANT;
//    else iREN -> IGRANT; else IDLE.
//  - Grant latency: request sampled in IDLE at edge N, RAM driven from N+1.
//  - DGRANT: ramaddr=daddr, ramstore=dstore; dWEN -> ramWEN=1, ramREN=0
//    (write wins if dREN&dWEN); else ramREN=1. dwait=0 only in a cycle
//    with ramstate==ACCESS; next state IDLE; dcnt+=1 (saturate at 15)
//    if iREN high in that cycle, else dcnt=0.
//  - IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0. iwait=0 only when
//    ramstate==ACCESS; next state IDLE; dcnt=0.
//  - BUSY/FREE/ERROR hold the grant, wait stays 1 (ERROR retried).
//  - Abort: granted requester drops its request before ack -> next state
//    IDLE, RAM enables low that same cycle, no ack, dcnt unchanged.
//  - One ack at a time; iwait and dwait never 0 in the same cycle.
//  - Back-to-back: every access costs >=1 IDLE cycle between grants.
//  - iload=dload=ramload always (combinational); valid only on own ack.
//  - Ungranted requester: wait=1, its address/data ignored.
//  - nRST mid-access: enables drop immediately, no ack, FSM to IDLE.
// TESTING
//  1 iREN=1, iaddr=0x100, ramstate BUSY 2 cyc then ACCESS, ramload=
//    0x8C010004 -> ramREN=1 from cycle 1, iwait=0 & iload=0x8C010004 in
//    cycle 3 only.
//  2 iREN & dREN together, daddr=0x200 -> DGRANT first (ramaddr=0x200),
//    dwait ack, one IDLE, then IGRANT with ramaddr=iaddr.
//  3 dWEN=1, daddr=0x80, dstore=0xDEADBEEF, dREN=1 -> ramWEN=1, ramREN=0,
//    ramstore=0xDEADBEEF; dwait=0 on ACCESS.
//  4 dREN held for 6 accesses, iREN held, ACCESS immediate -> exactly 4
//    data acks, then instruction ack, then data resumes (dcnt=0).
//  5 IGRANT, drop iREN while ramstate=BUSY -> ramREN=0 same cycle, no
//    iwait=0, state IDLE next edge.
//  6 nRST pulsed low mid-DGRANT -> ramREN/ramWEN=0 async, dwait=1, after
//    release pending dREN re-granted in 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access; data wins
// unless a pending fetch has already watched DSTREAK_MAX data grants go by.
module mem_arbiter #(
  parameter int DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] DMAX       = 4'(DSTREAK_MAX);
  localparam logic [3:0] DCNT_SAT   = 4'd15;

  state_t     state_q, state_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       dreq;
  logic       istarved;

  assign dreq     = dREN | dWEN;
  assign istarved = iREN && (dcnt_q >= DMAX);

  // Read data is shared; each requester only trusts it in its own ack cycle.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // RAM controls decode from the registered state, so reset drops them at once.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE: begin
        if (dreq && !istarved) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (dWEN) begin
            ramWEN = 1'b1;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (iREN) begin
              dcnt_d = (dcnt_q == DCNT_SAT) ? DCNT_SAT : dcnt_q + 4'd1;
            end else begin
              dcnt_d = 4'd0;
            end
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait   = 1'b0;
            state_d = IDLE;
            dcnt_d  = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter; inputs change on the falling edge, outputs
// are sampled 1ns later, well away from the rising edge.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  mem_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h1234_5678; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN: got %b want 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN: got %b want 0", ramWEN); end
    checks++; if (ramaddr !== 32'd0) begin errors++; $display("FAIL rst_ramaddr: got %h want 0", ramaddr); end
    checks++; if (ramstore !== 32'd0) begin errors++; $display("FAIL rst_ramstore: got %h want 0", ramstore); end
    checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("FAIL rst_waits: got %b want 11", {iwait, dwait}); end
    checks++; if (iload !== 32'h1234_5678 || dload !== 32'h1234_5678) begin errors++; $display("FAIL rst_load_pass: got %h/%h want 12345678", iload, dload); end
    next_cycle();
    nRST = 1'b1;
    next_cycle();
  endtask

  task automatic test_ifetch();
    iREN = 1; iaddr = 32'h100; ramstate = BUSY; ramload = 32'h8C01_0004; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL if_c0_ren: got %b want 0", ramREN); end
    next_cycle(); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL if_c1: got ren=%b addr=%h want 1/100", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL if_c1_iwait: got %b want 1", iwait); end
    next_cycle(); #1;
    checks++; if (ramREN !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL if_c2: got ren=%b iwait=%b want 1/1", ramREN, iwait); end
    next_cycle(); ramstate = ACCESS; #1;
    checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL if_c3_ack: got iwait=%b dwait=%b want 0/1", iwait, dwait); end
    checks++; if (iload !== 32'h8C01_0004) begin errors++; $display("FAIL if_c3_iload: got %h want 8c010004", iload); end
    next_cycle(); iREN = 0; #1;
    checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL if_c4_idle: got iwait=%b ren=%b want 1/0", iwait, ramREN); end
    next_cycle();
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200; ramstate = ACCESS; #1;
    next_cycle(); #1;
    checks++; if (ramaddr !== 32'h200 || ramREN !== 1'b1) begin errors++; $display("FAIL pri_dgrant: got addr=%h ren=%b want 200/1", ramaddr, ramREN); end
    checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL pri_dack: got dwait=%b iwait=%b want 0/1", dwait, iwait); end
    next_cycle(); dREN = 0; #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL pri_gap: got ren=%b dwait=%b iwait=%b want 0/1/1", ramREN, dwait, iwait); end
    next_cycle(); #1;
    checks++; if (ramaddr !== 32'h300 || ramREN !== 1'b1 || iwait !== 1'b0) begin errors++; $display("FAIL pri_igrant: got addr=%h ren=%b iwait=%b want 300/1/0", ramaddr, ramREN, iwait); end
    next_cycle(); iREN = 0;
    next_cycle();
  endtask

  task automatic test_write();
    dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; ramstate = BUSY; #1;
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wr_c0_wen: got %b want 0", ramWEN); end
    next_cycle(); #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wr_en: got wen=%b ren=%b want 1/0", ramWEN, ramREN); end
    checks++; if (ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h80) begin errors++; $display("FAIL wr_bus: got store=%h addr=%h want deadbeef/80", ramstore, ramaddr); end
    checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL wr_busy_wait: got %b want 1", dwait); end
    next_cycle(); ramstate = ACCESS; #1;
    checks++; if (dwait !== 1'b0 || ramWEN !== 1'b1) begin errors++; $display("FAIL wr_ack: got dwait=%b wen=%b want 0/1", dwait, ramWEN); end
    next_cycle(); dWEN = 0; dREN = 0; #1;
    checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL wr_done: got wen=%b dwait=%b want 0/1", ramWEN, dwait); end
    next_cycle();
  endtask

  task automatic test_streak();
    logic [7:0] seq [6];
    logic [7:0] want [6];
    int         n = 0;
    bit         prev_ack = 0;
    want = '{"D", "D", "D", "D", "I", "D"};
    dREN = 1; iREN = 1; daddr = 32'h400; iaddr = 32'h500; ramstate = ACCESS;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      if (cyc > 0) next_cycle();
      #1;
      checks++; if (!iwait && !dwait) begin errors++; $display("FAIL st_dual_ack: cycle %0d both waits low", cyc); end
      if (prev_ack) begin
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL st_no_gap: cycle %0d ren=%b want 0 after ack", cyc, ramREN); end
      end
      prev_ack = 0;
      if (!dwait) begin seq[n] = "D"; n++; prev_ack = 1; end
      else if (!iwait) begin seq[n] = "I"; n++; prev_ack = 1; end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL st_budget: got %0d acks want 6 within 40 cycles", n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (seq[k] !== want[k]) begin errors++; $display("FAIL st_order[%0d]: got %s want %s", k, seq[k], want[k]); end
    end
    next_cycle(); dREN = 0; iREN = 0;
    next_cycle();
  endtask

  task automatic test_abort();
    iREN = 1; iaddr = 32'h600; ramstate = BUSY;
    next_cycle(); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin errors++; $display("FAIL ab_grant: got ren=%b addr=%h want 1/600", ramREN, ramaddr); end
    next_cycle(); iREN = 0; #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ab_drop: got ren=%b iwait=%b want 0/1", ramREN, iwait); end
    next_cycle(); iREN = 1; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL ab_idle: got ren=%b want 0 (fsm in IDLE)", ramREN); end
    next_cycle(); ramstate = ACCESS; #1;
    checks++; if (ramREN !== 1'b1 || iwait !== 1'b0) begin errors++; $display("FAIL ab_regrant: got ren=%b iwait=%b want 1/0", ramREN, iwait); end
    next_cycle(); iREN = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    dREN = 1; daddr = 32'h700; ramstate = BUSY;
    next_cycle(); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700) begin errors++; $display("FAIL rm_grant: got ren=%b addr=%h want 1/700", ramREN, ramaddr); end
    #2 nRST = 1'b0; #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL rm_async: got ren=%b wen=%b dwait=%b want 0/0/1", ramREN, ramWEN, dwait); end
    next_cycle(); nRST = 1'b1; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rm_release_idle: got ren=%b want 0", ramREN); end
    next_cycle(); ramstate = ACCESS; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700 || dwait !== 1'b0) begin errors++; $display("FAIL rm_regrant: got ren=%b addr=%h dwait=%b want 1/700/0", ramREN, ramaddr, dwait); end
    next_cycle(); dREN = 0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_write();
    test_streak();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
